or_64: RTL and testbench



---
 rtl/or_64.sv | 70 +++++++
 tb/tb_or_64.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/or_64.sv
// Registered WIDTH-bit bitwise OR with zero/all-ones flags and a popcount of the result.
// Optional sticky-OR accumulation is enabled by defining OR_64_ACCUM_EN (adds input port accum).
module or_64 #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
`ifdef OR_64_ACCUM_EN
  input  logic             accum,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             all_ones,
  output logic [CNT_W-1:0] ones_count
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW     = 1 << LEVELS;

  // Pairwise adder tree: leaves are the bits, padded with zeros up to a power of two.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] sums [PW];
    for (int i = 0; i < PW; i++) begin
      sums[i] = '0;
      if (i < WIDTH) sums[i] = CNT_W'(v[i]);
    end
    for (int step = 1; step < PW; step = step * 2) begin
      for (int i = 0; i + step < PW; i = i + 2 * step) begin
        sums[i] = sums[i] + sums[i + step];
      end
    end
    return sums[0];
  endfunction

  logic [WIDTH-1:0] next_y;
  logic [CNT_W-1:0] next_count;

  always_comb begin
    next_y = a | b;
`ifdef OR_64_ACCUM_EN
    if (accum) next_y = y | a | b;
`endif
    next_count = popcount(next_y);
  end

  // Flags are derived from the value being captured so they land on the same edge as y.
  always_ff @(posedge clk) begin
    if (reset) begin
      y          <= '0;
      out_valid  <= 1'b0;
      zero       <= 1'b1;
      all_ones   <= 1'b0;
      ones_count <= '0;
    end else if (in_valid) begin
      y          <= next_y;
      out_valid  <= 1'b1;
      zero       <= (next_y == '0);
      all_ones   <= (&next_y);
      ones_count <= next_count;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_or_64.sv
// Scoreboard bench for or_64: driver queues expected results, a monitor checks each edge.
// Define OR_64_ACCUM_EN for both RTL and bench to exercise sticky accumulation.
module tb_or_64;

  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             accum = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             zero;
  logic             all_ones;
  logic [CNT_W-1:0] ones_count;

  exp_t exp_q[$];
  exp_t hold_val;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  or_64 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
`ifdef OR_64_ACCUM_EN
    .accum      (accum),
`endif
    .a          (a),
    .b          (b),
    .y          (y),
    .out_valid  (out_valid),
    .zero       (zero),
    .all_ones   (all_ones),
    .ones_count (ones_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge; queue the expected result for real captures.
  task automatic apply_stimulus(input logic rst, input logic v, input logic acc,
                                input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic [WIDTH-1:0] exp_y, input int exp_cnt);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    accum    = acc;
    a        = av;
    b        = bv;
    if (v && !rst) begin
      e.y   = exp_y;
      e.cnt = CNT_W'(exp_cnt);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      apply_stimulus(1'b0, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, '0, 0);
  endtask

  // Monitor: reset edges must show reset values, out_valid pops the scoreboard, otherwise hold.
  initial begin
    logic rst_q;
    exp_t e;
    forever begin
      @(posedge clk);
      rst_q = reset;
      #1;
      if (rst_q) begin
        started = 1'b1;
        check_output("reset_y", y, '0);
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_zero", 64'(zero), 64'd1);
        check_output("reset_all_ones", 64'(all_ones), 64'd0);
        check_output("reset_count", 64'(ones_count), 64'd0);
        hold_val = '0;
      end else if (started) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_out_valid", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_output("y", y, e.y);
            check_output("ones_count", 64'(ones_count), 64'(e.cnt));
            check_output("zero", 64'(zero), 64'(e.y == '0));
            check_output("all_ones", 64'(all_ones), 64'(&e.y));
            hold_val = e;
          end
        end else begin
          check_output("hold_y", y, hold_val.y);
          check_output("hold_count", 64'(ones_count), 64'(hold_val.cnt));
          if (exp_q.size() != 0) begin
            check_output("missing_out_valid", 64'(out_valid), 64'd1);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    $display("[TB] starting or_64 bench");
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 0);
    idle(1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                   64'hFFFFFFFFFFFFFFFF, 64);
    idle(1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555,
                   64'hFFFFFFFFFFFFFFFF, 64);
    idle(1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321,
                   64'h1FFDDFF99FFDDFF1, 50);
    idle(5);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF,
                   64'hFFFFFFFFFFFFFFFF, 64);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0000000000000001, 64'h8000000000000000,
                   64'h8000000000000001, 2);
    idle(1);

    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h0, 64'h0, 64'h0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                   64'hFFFFFFFFFFFFFFFF, 64);
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555,
                   64'hFFFFFFFFFFFFFFFF, 64);
    idle(1);

    apply_stimulus(1'b0, 1'b1, 1'b0, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321,
                   64'h1FFDDFF99FFDDFF1, 50);
    apply_stimulus(1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, '0, 0);
    idle(2);

`ifdef OR_64_ACCUM_EN
    apply_stimulus(1'b0, 1'b1, 1'b0, 64'hFFFFFFFF00000000, 64'h0,
                   64'hFFFFFFFF00000000, 32);
    apply_stimulus(1'b0, 1'b1, 1'b1, 64'h0, 64'h00000000FFFFFFFF,
                   64'hFFFFFFFFFFFFFFFF, 64);
    idle(1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 64'h0, 64'h0, '0, 0);
    idle(1);
`endif

    idle(2);
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
